// File: rtl/multi_cycle_control.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the
// R/ADDI/SLTI/LW/SW/BEQ(/J) subset, with retired-instruction counter and illegal-opcode trap.
module multi_cycle_control #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int JUMP_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [OP_W-1:0]    instr_op_i,
   input  logic               mem_ready_i,
   output logic               PCWrite_o,
   output logic               Branch_o,
   output logic               Jump_o,
   output logic               IorD_o,
   output logic               IRWrite_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               ALUSrc_o,
   output logic [ALUOP_W-1:0] ALU_op_o,
   output logic               RegDst_o,
   output logic               MemtoReg_o,
   output logic               RegWrite_o,
   output logic               instr_done_o,
   output logic               illegal_o,
   output logic [CNT_W-1:0]   instr_count_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
   localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'h0A);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b011);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              illegal_q, illegal_d;

   logic               pc_write, branch, jump, iord, ir_write, mem_read, mem_write;
   logic               alu_src, reg_dst, mem_to_reg, reg_write, retire;
   logic [ALUOP_W-1:0] alu_op;

   function automatic logic is_exec_op(input logic [OP_W-1:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_SLTI) ||
             (op == OP_LW) || (op == OP_SW)  || (op == OP_BEQ);
   endfunction

   function automatic logic [ALUOP_W-1:0] alu_code(input logic [OP_W-1:0] op);
      if (op == OP_R)         return ALU_FUNCT;
      else if (op == OP_SLTI) return ALU_SLT;
      else if (op == OP_BEQ)  return ALU_SUB;
      else                    return ALU_ADD;
   endfunction

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      pc_write   = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready_i) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Legality and the jump are decided from the live opcode; op_q only holds it afterwards
            op_d = instr_op_i;
            if (is_exec_op(instr_op_i)) begin
               state_d = S_EXEC;
            end else if ((JUMP_EN != 0) && (instr_op_i == OP_J)) begin
               pc_write = 1'b1;
               jump     = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_EXEC: begin
            alu_op  = alu_code(op_q);
            alu_src = (op_q != OP_R) && (op_q != OP_BEQ);
            if (op_q == OP_BEQ) begin
               branch  = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            iord      = 1'b1;
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
            if (mem_ready_i) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_R);
            mem_to_reg = (op_q == OP_LW);
            alu_op     = alu_code(op_q);
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      cnt_d     = cnt_q + CNT_W'(retire);
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Reset forces every output low even though the state register already reads FETCH
   assign PCWrite_o     = rst_i & pc_write;
   assign Branch_o      = rst_i & branch;
   assign Jump_o        = rst_i & jump;
   assign IorD_o        = rst_i & iord;
   assign IRWrite_o     = rst_i & ir_write;
   assign MemRead_o     = rst_i & mem_read;
   assign MemWrite_o    = rst_i & mem_write;
   assign ALUSrc_o      = rst_i & alu_src;
   assign ALU_op_o      = rst_i ? alu_op : '0;
   assign RegDst_o      = rst_i & reg_dst;
   assign MemtoReg_o    = rst_i & mem_to_reg;
   assign RegWrite_o    = rst_i & reg_write;
   assign instr_done_o  = rst_i & retire;
   assign illegal_o     = illegal_q;
   assign instr_count_o = cnt_q;

endmodule
